// File: rtl/lcd_sequencer.sv
// rtl/lcd_sequencer.sv - HD44780 init and two-line refresh sequencer for the DE2 16x2 LCD (optional LCD_SEQ_AUTOREFRESH_EN)
module lcd_sequencer #(
  parameter int PWR_CYCLES = 750000,
  parameter int GAP_CYCLES = 100000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iWR_EN,
  input  logic [4:0] iWR_ADDR,
  input  logic [7:0] iWR_DATA,
  input  logic       iUpdate,
  output logic       oBusy,
  output logic [7:0] oLCD_DATA,
  output logic       oLCD_RS,
  output logic       oLCD_Start,
  input  logic       iLCD_Done
);

  localparam logic [2:0] S_PWR   = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_IDLE  = 3'd4;

  localparam logic [19:0] PWR_END = 20'(PWR_CYCLES);
  localparam logic [19:0] GAP_END = 20'(GAP_CYCLES - 1);
  localparam logic [5:0]  INIT_LAST = 6'd3;
  localparam logic [5:0]  REFR_LAST = 6'd33;

  logic [2:0]  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [5:0]  step_q, step_d;
  logic        refr_q, refr_d;   // 0 = init list, 1 = refresh list
  logic        pend_q, pend_d;
  logic        done_prev_q;
  logic [7:0]  data_q;
  logic        rs_q;
  logic [7:0]  buf_q [32];

  logic [7:0]  cur_data;
  logic        cur_rs;
  logic [4:0]  rd_idx;
  logic [5:0]  last_step;
  logic        ar_wrap;

`ifdef LCD_SEQ_AUTOREFRESH_EN
  localparam logic [19:0] AR_END = 20'(GAP_CYCLES * 8 - 1);
  logic [19:0] ar_cnt_q;

  // Free-running period counter that requests a refresh on every wrap
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) ar_cnt_q <= '0;
    else if (ar_cnt_q == AR_END) ar_cnt_q <= '0;
    else ar_cnt_q <= ar_cnt_q + 20'd1;
  end

  assign ar_wrap = (ar_cnt_q == AR_END);
`else
  assign ar_wrap = 1'b0;
`endif

  // Decode the byte and RS flag for the current list step; buffer read happens in the issue cycle
  always_comb begin
    cur_data = 8'h00;
    cur_rs   = 1'b0;
    rd_idx   = 5'd0;
    if (!refr_q) begin
      case (step_q[1:0])
        2'd0:    cur_data = 8'h38;
        2'd1:    cur_data = 8'h0C;
        2'd2:    cur_data = 8'h01;
        default: cur_data = 8'h06;
      endcase
    end else if (step_q == 6'd0) begin
      cur_data = 8'h80;
    end else if (step_q == 6'd17) begin
      cur_data = 8'hC0;
    end else begin
      cur_rs = 1'b1;
      if (step_q < 6'd17) rd_idx = 5'(step_q - 6'd1);
      else                rd_idx = 5'(step_q - 6'd2);
      cur_data = buf_q[rd_idx];
    end
  end

  assign last_step = refr_q ? REFR_LAST : INIT_LAST;

  // Next-state logic: power-up wait, issue/wait/gap per step, idle with pending refresh
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    refr_d  = refr_q;
    pend_d  = pend_q;
    if ((iUpdate && state_q != S_IDLE) || ar_wrap) pend_d = 1'b1;
    case (state_q)
      S_PWR: begin
        if (cnt_q == PWR_END) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
          step_d  = '0;
          refr_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // Only a fresh rising edge counts; a stale high done from the previous write is ignored
        if (iLCD_Done && !done_prev_q) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_END) begin
          cnt_d = '0;
          if (step_q != last_step) begin
            step_d  = step_q + 6'd1;
            state_d = S_ISSUE;
          end else if (pend_d) begin
            pend_d  = 1'b0;
            step_d  = '0;
            refr_d  = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_IDLE: begin
        if (iUpdate || pend_d) begin
          pend_d  = 1'b0;
          step_d  = '0;
          refr_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_PWR;
    endcase
  end

  // Sequencer state registers plus done edge history and held output byte
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= S_PWR;
      cnt_q       <= '0;
      step_q      <= '0;
      refr_q      <= 1'b0;
      pend_q      <= 1'b0;
      done_prev_q <= 1'b0;
      data_q      <= 8'h00;
      rs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      refr_q      <= refr_d;
      pend_q      <= pend_d;
      done_prev_q <= iLCD_Done;
      if (state_q == S_ISSUE) begin
        data_q <= cur_data;
        rs_q   <= cur_rs;
      end
    end
  end

  // Character buffer: spaces after reset, one host write per cycle in any state
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
    end else if (iWR_EN) begin
      buf_q[iWR_ADDR] <= iWR_DATA;
    end
  end

  assign oLCD_Start = (state_q == S_ISSUE);
  assign oLCD_DATA  = oLCD_Start ? cur_data : data_q;
  assign oLCD_RS    = oLCD_Start ? cur_rs : rs_q;
  assign oBusy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb/tb_lcd_sequencer.sv - scoreboard bench for lcd_sequencer with a write-engine model
module tb_lcd_sequencer;

  localparam int P   = 10;
  localparam int G   = 4;
  localparam int LAT = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       upd;
  logic       busy;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_start;
  logic       lcd_done;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         at;   // >=0 exact start cycle, -1 start must follow last done by G+1
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem [32];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done = 0;
  int n_starts = 0;
  int clr_delay = 1;

  lcd_sequencer #(.PWR_CYCLES(P), .GAP_CYCLES(G)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iWR_EN(wr_en), .iWR_ADDR(wr_addr),
    .iWR_DATA(wr_data), .iUpdate(upd), .oBusy(busy), .oLCD_DATA(lcd_data),
    .oLCD_RS(lcd_rs), .oLCD_Start(lcd_start), .iLCD_Done(lcd_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input logic rs, input logic [7:0] data, input int at);
    exp_t e;
    e.rs = rs; e.data = data; e.at = at;
    sb.push_back(e);
  endtask

  task automatic push_init(input int first_at);
    push(1'b0, 8'h38, first_at);
    push(1'b0, 8'h0C, -1);
    push(1'b0, 8'h01, -1);
    push(1'b0, 8'h06, -1);
  endtask

  task automatic push_refresh(input int first_at);
    push(1'b0, 8'h80, first_at);
    for (int i = 0; i < 16; i++) push(1'b1, mem[i], -1);
    push(1'b0, 8'hC0, -1);
    for (int i = 16; i < 32; i++) push(1'b1, mem[i], -1);
  endtask

  task automatic write_byte(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    mem[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL %s: timeout, busy got 1 expected 0", name);
    end else begin
      chk({name, "_cycle"}, cyc, last_done + G + 1);
    end
  endtask

  task automatic wait_starts(input int target, input int budget);
    int n = 0;
    while (n_starts < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n_starts < target) begin
      checks++; errors++;
      $display("FAIL wait_starts: got %0d starts expected %0d", n_starts, target);
    end
  endtask

  // Cycle count since reset release
  initial forever begin
    @(posedge clk);
    cyc = rst_n ? cyc + 1 : 0;
  end

  // Write engine model: clears done after clr_delay cycles, raises it LAT cycles after start
  initial begin : engine
    int cnt = 0;
    int clr = 0;
    lcd_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lcd_done = 1'b0; cnt = 0; clr = 0;
      end else begin
        if (clr > 0) begin
          clr--;
          if (clr == 0) lcd_done = 1'b0;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            lcd_done = 1'b1;
            last_done = cyc;
          end
        end
        if (lcd_start) begin
          clr = clr_delay;
          cnt = LAT;
        end
      end
    end
  end

  // Monitor: pop and compare each start pulse, check held data between pulses
  initial begin : monitor
    exp_t e;
    logic [7:0] held = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 8'h00;
      end else if (lcd_start) begin
        n_starts++;
        held = lcd_data;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_start: got data 0x%0h expected no start (cycle %0d)", lcd_data, cyc);
        end else begin
          e = sb.pop_front();
          chk("start_rs", lcd_rs, e.rs);
          chk("start_data", lcd_data, e.data);
          if (e.at >= 0) chk("start_cycle", cyc, e.at);
          else           chk("start_gap", cyc, last_done + G + 1);
        end
      end else begin
        chk("data_held", lcd_data, held);
      end
    end
  end

  initial begin
    int base;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; upd = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h20;
    repeat (3) @(negedge clk);
    chk("reset_start", lcd_start, 0);
    chk("reset_data", lcd_data, 0);
    chk("reset_rs", lcd_rs, 0);
    chk("reset_busy", busy, 1);

    // Power-up init
    push_init(P + 1);
    rst_n = 1'b1;
    wait_idle("init_idle", 200);
    chk("init_sb_empty", sb.size(), 0);

    // HELLO refresh with done held high past the start pulse
    clr_delay = 3;
    write_byte(5'd0, 8'h48);
    write_byte(5'd1, 8'h45);
    write_byte(5'd2, 8'h4C);
    write_byte(5'd3, 8'h4C);
    write_byte(5'd4, 8'h4F);
    upd = 1'b1;
    push_refresh(cyc + 1);
    @(negedge clk);
    upd = 1'b0;
    chk("refresh_busy_now", busy, 1);
    chk("refresh_start_now", lcd_start, 1);
    wait_idle("hello_idle", 800);
    chk("hello_sb_empty", sb.size(), 0);
    clr_delay = 1;

    // Line 2 content, reset in the middle of step 20
    write_byte(5'd16, 8'h41);
    write_byte(5'd17, 8'h42);
    write_byte(5'd31, 8'h5A);
    base = n_starts;
    upd = 1'b1;
    push_refresh(cyc + 1);
    @(negedge clk);
    upd = 1'b0;
    wait_starts(base + 21, 600);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_start", lcd_start, 0);
    chk("abort_data", lcd_data, 0);
    chk("abort_rs", lcd_rs, 0);
    chk("abort_busy", busy, 1);
    sb.delete();
    for (int i = 0; i < 32; i++) mem[i] = 8'h20;
    repeat (2) @(negedge clk);

    // Re-init with a 3-cycle update request collapsing into one refresh of spaces
    base = n_starts;
    push_init(P + 1);
    push_refresh(-1);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    upd = 1'b1;
    repeat (3) @(negedge clk);
    upd = 1'b0;
    wait_idle("reinit_idle", 1200);
    chk("reinit_sb_empty", sb.size(), 0);
    repeat (60) @(negedge clk);
    chk("single_refresh_starts", n_starts - base, 38);
    chk("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $finish;
  end

endmodule

// File: doc/lcd_sequencer.md
# lcd_sequencer

Command/character sequencer for the DE2 16x2 character LCD. It sits between host logic and the single-transaction LCD write engine, and drives that engine's data, RS and start inputs. It runs the HD44780 power-up initialisation once after reset. It then refreshes both display lines from an internal 32-byte character buffer whenever the host requests an update.

## Interface
- PWR_CYCLES, 750000: idle cycles after reset before the first init command (15 ms at 50 MHz).
- GAP_CYCLES, 100000: idle cycles after every completed transaction before the next one is issued (2 ms; covers Clear Display).
- Both parameters must fit in a 20-bit counter and be ≥ 1.

Ports. Reset iRST_N, asynchronous, active-low; clock iCLK.
- iCLK  in  1  system clock
- iRST_N  in  1  async active-low reset
- iWR_EN  in  1  buffer write strobe
- iWR_ADDR  in  5  buffer index; 0–15 is line 1, 16–31 is line 2
- iWR_DATA  in  8  character code
- iUpdate  in  1  refresh request; level sampled each cycle, rising edge not required
- oBusy  out  1  high while init or refresh is in progress
- oLCD_DATA  out  8  to write engine data input
- oLCD_RS  out  1  to write engine RS; 0 = command, 1 = character
- oLCD_Start  out  1  to write engine start input
- iLCD_Done  in  1  from write engine done output

## Operation
- States: PWR, ISSUE, WAIT_DONE, GAP, IDLE.
- PWR: count PWR_CYCLES, then ISSUE with step 0 of the init list.
- Init list, all RS=0: 0x38, 0x0C, 0x01, 0x06.
- Refresh list, 34 steps:
  - 0x80, RS=0
  - buf[0..15], RS=1
  - 0xC0, RS=0
  - buf[16..31], RS=1
- ISSUE: load oLCD_DATA and oLCD_RS for the current step and pulse oLCD_Start high for exactly one cycle. Then go to WAIT_DONE.
- oLCD_DATA and oLCD_RS are held constant from ISSUE until the next ISSUE.
- WAIT_DONE: wait for a rising edge of iLCD_Done, using a registered previous value. A level that was high before the start pulse is never accepted, because the engine clears done one cycle after the start edge.
- GAP: count GAP_CYCLES. Then:
  - If list steps remain: next step, go to ISSUE.
  - After the last init step: IDLE, or ISSUE if an update is pending.
  - After the last refresh step: IDLE, or restart the refresh if an update is pending.
- IDLE: if iUpdate or the pending flag is set, clear pending, go to ISSUE at refresh step 0.
- Pending flag: iUpdate high in any state other than IDLE sets a single-deep pending flag. Multiple requests collapse into one refresh.
- Buffer writes:
  - Accepted in every state, one byte per cycle on iWR_EN.
  - A character byte is read at its ISSUE cycle. A write landing before that cycle is displayed in the current refresh; later writes wait for the next refresh.
  - A same-cycle write and ISSUE to the same index sends the old byte.
- oBusy = (state != IDLE).

## Timing
- Reset values:
  - oLCD_Start=0, oLCD_DATA=0x00, oLCD_RS=0, oBusy=1.
  - All buffer bytes 0x20; pending=0; state PWR; counters 0.
- Reset mid-operation aborts immediately. Init reruns from PWR and the buffer returns to spaces.
- First oLCD_Start pulse: cycle PWR_CYCLES+1 after reset release.
- Per transaction: 1 issue cycle + engine latency + 1 edge-detect cycle + GAP_CYCLES.
- The next oLCD_Start pulse comes GAP_CYCLES+1 cycles after the iLCD_Done rising edge.
- Refresh start: iUpdate sampled high in IDLE gives oBusy=1 on the next cycle and oLCD_Start=1 on the same cycle.
- There is no timeout: a missing iLCD_Done holds WAIT_DONE indefinitely.

## Configuration
- LCD_SEQ_AUTOREFRESH_EN
  - Defined: a 20-bit free-running counter of GAP_CYCLES×8 cycles sets the pending flag on each wrap. The display then refreshes periodically without iUpdate.
  - Undefined: refreshes occur only on iUpdate; the counter is not built.

## Test plan
- Reset release, PWR_CYCLES=10, GAP_CYCLES=4, engine model done 5 cycles after start -> four start pulses with RS=0 carrying 0x38, 0x0C, 0x01, 0x06 in that order; first pulse at cycle 11; then oBusy=0.
- Write "HELLO" to indices 0–4, pulse iUpdate -> 34 transactions: 0x80, "HELLO", 11×0x20, 0xC0, 16×0x20; RS flags as listed; oBusy low after the last gap.
- iUpdate held high for 3 cycles during init -> exactly one refresh follows init, and only one.
- iLCD_Done already high when start pulses -> no advance until done falls and rises again.
- Assert iRST_N low during refresh step 20 -> outputs return to reset values; later, full init reruns; buffer reads back as spaces.
- With LCD_SEQ_AUTOREFRESH_EN and no iUpdate -> a refresh starts within GAP_CYCLES×8 cycles of idle.
